// File: rtl/fft_bfly_r2.sv
// Fully pipelined radix-2 DIT butterfly: x0 = d0 + d1*w, x1 = d0 - d1*w, with
// optional conjugated twiddle, rounding/block-scaling, saturation and frame sideband.
module fft_bfly_r2 #(
    parameter int DW  = 28,
    parameter int TW  = 16,
    parameter int OW  = DW + 1,
    parameter int SW  = 3,
    parameter bit RND = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              ifft,
    input  logic [SW-1:0]     shift,
    input  logic [2*DW-1:0]   data0,
    input  logic [2*DW-1:0]   data1,
    input  logic [2*TW-1:0]   w1,
    input  logic              clr_ovf,
    output logic              out_valid,
    output logic              out_last,
    output logic [2*OW-1:0]   x0,
    output logic [2*OW-1:0]   x1,
    output logic              out_sat,
    output logic              ovf_sticky,
    output logic [7:0]        out_cnt
);
    localparam int PW = DW + TW;
    localparam int CW = PW + 1;
    localparam int BW = PW + 2;
    localparam int RW = BW + 1;
    localparam int KW = 8;

    localparam logic signed [TW-1:0] WMIN = {1'b1, {(TW-1){1'b0}}};
    localparam logic signed [TW-1:0] WMAX = ~WMIN;

    logic                 v1_q, last1_q;
    logic [SW-1:0]        sh1_q;
    logic signed [DW-1:0] d0Re1_q, d0Im1_q, d1Re1_q, d1Im1_q;
    logic signed [TW-1:0] wRe1_q, wIm1_q, wIm1_d, wImIn;

    logic                 v2_q, last2_q;
    logic [SW-1:0]        sh2_q;
    logic signed [DW-1:0] d0Re2_q, d0Im2_q;
    logic signed [PW-1:0] rr2_q, ii2_q, ri2_q, ir2_q;

    logic                 v3_q, last3_q;
    logic [SW-1:0]        sh3_q;
    logic signed [CW-1:0] pRe3_q, pIm3_q;
    logic signed [BW-1:0] d0aRe3_q, d0aIm3_q;

    logic                 v4_q, last4_q;
    logic [SW-1:0]        sh4_q;
    logic signed [BW-1:0] sRe4_q, sIm4_q, tRe4_q, tIm4_q;

    logic [KW-1:0]        kAmt;
    logic signed [OW-1:0] x0Re_d, x0Im_d, x1Re_d, x1Im_d;
    logic                 sat0, sat1, sat2, sat3;

    logic                 outValid_q, outLast_q, outSat_q, ovf_q;
    logic signed [OW-1:0] x0Re_q, x0Im_q, x1Re_q, x1Im_q;
    logic [7:0]           cnt_q;

    // Conjugation negates the twiddle imag part; the most negative code has no
    // positive counterpart so it clamps to the largest positive code.
    always_comb begin
        wImIn  = w1[TW-1:0];
        wIm1_d = wImIn;
        if (ifft) begin
            wIm1_d = (wImIn == WMIN) ? WMAX : -wImIn;
        end
    end

    function automatic logic [OW:0] scaleSat(input logic signed [BW-1:0] v,
                                             input logic [KW-1:0] k);
        logic signed [RW-1:0] r;
        logic signed [RW-1:0] rMax;
        logic signed [RW-1:0] rMin;
        rMax = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
        rMin = ~rMax;
        r    = RW'(v);
        if (RND) begin
            r = r + (RW'(1) <<< (k - KW'(1)));
        end
        r = r >>> k;
        if (r > rMax) begin
            scaleSat = {1'b1, rMax[OW-1:0]};
        end else if (r < rMin) begin
            scaleSat = {1'b1, rMin[OW-1:0]};
        end else begin
            scaleSat = {1'b0, r[OW-1:0]};
        end
    endfunction

    always_comb begin
        kAmt             = KW'(TW - 2) + KW'(sh4_q);
        {sat0, x0Re_d}   = scaleSat(sRe4_q, kAmt);
        {sat1, x0Im_d}   = scaleSat(sIm4_q, kAmt);
        {sat2, x1Re_d}   = scaleSat(tRe4_q, kAmt);
        {sat3, x1Im_d}   = scaleSat(tIm4_q, kAmt);
    end

    // Datapath registers advance every cycle; only the valid bits give them meaning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;  last1_q  <= 1'b0;  sh1_q <= '0;
            d0Re1_q  <= '0;    d0Im1_q  <= '0;    d1Re1_q <= '0;  d1Im1_q <= '0;
            wRe1_q   <= '0;    wIm1_q   <= '0;
            v2_q     <= 1'b0;  last2_q  <= 1'b0;  sh2_q <= '0;
            d0Re2_q  <= '0;    d0Im2_q  <= '0;
            rr2_q    <= '0;    ii2_q    <= '0;    ri2_q <= '0;    ir2_q <= '0;
            v3_q     <= 1'b0;  last3_q  <= 1'b0;  sh3_q <= '0;
            pRe3_q   <= '0;    pIm3_q   <= '0;    d0aRe3_q <= '0; d0aIm3_q <= '0;
            v4_q     <= 1'b0;  last4_q  <= 1'b0;  sh4_q <= '0;
            sRe4_q   <= '0;    sIm4_q   <= '0;    tRe4_q <= '0;   tIm4_q <= '0;
        end else begin
            v1_q     <= in_valid;
            last1_q  <= in_valid & in_last;
            sh1_q    <= shift;
            d0Re1_q  <= data0[2*DW-1:DW];
            d0Im1_q  <= data0[DW-1:0];
            d1Re1_q  <= data1[2*DW-1:DW];
            d1Im1_q  <= data1[DW-1:0];
            wRe1_q   <= w1[2*TW-1:TW];
            wIm1_q   <= wIm1_d;

            v2_q     <= v1_q;
            last2_q  <= last1_q;
            sh2_q    <= sh1_q;
            d0Re2_q  <= d0Re1_q;
            d0Im2_q  <= d0Im1_q;
            rr2_q    <= PW'(d1Re1_q) * PW'(wRe1_q);
            ii2_q    <= PW'(d1Im1_q) * PW'(wIm1_q);
            ri2_q    <= PW'(d1Re1_q) * PW'(wIm1_q);
            ir2_q    <= PW'(d1Im1_q) * PW'(wRe1_q);

            v3_q     <= v2_q;
            last3_q  <= last2_q;
            sh3_q    <= sh2_q;
            pRe3_q   <= CW'(rr2_q) - CW'(ii2_q);
            pIm3_q   <= CW'(ri2_q) + CW'(ir2_q);
            d0aRe3_q <= BW'(d0Re2_q) <<< (TW - 2);
            d0aIm3_q <= BW'(d0Im2_q) <<< (TW - 2);

            v4_q     <= v3_q;
            last4_q  <= last3_q;
            sh4_q    <= sh3_q;
            sRe4_q   <= d0aRe3_q + BW'(pRe3_q);
            sIm4_q   <= d0aIm3_q + BW'(pIm3_q);
            tRe4_q   <= d0aRe3_q - BW'(pRe3_q);
            tIm4_q   <= d0aIm3_q - BW'(pIm3_q);
        end
    end

    // Output stage: results and out_sat only move on valid slots; a new
    // saturation beats a simultaneous clear of the sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outSat_q   <= 1'b0;
            ovf_q      <= 1'b0;
            x0Re_q     <= '0;
            x0Im_q     <= '0;
            x1Re_q     <= '0;
            x1Im_q     <= '0;
            cnt_q      <= '0;
        end else begin
            outValid_q <= v4_q;
            outLast_q  <= v4_q & last4_q;
            if (v4_q) begin
                x0Re_q   <= x0Re_d;
                x0Im_q   <= x0Im_d;
                x1Re_q   <= x1Re_d;
                x1Im_q   <= x1Im_d;
                outSat_q <= sat0 | sat1 | sat2 | sat3;
            end
            if (outValid_q && outSat_q) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
            if (outValid_q) begin
                cnt_q <= outLast_q ? 8'd0 : cnt_q + 8'd1;
            end
        end
    end

    assign out_valid  = outValid_q;
    assign out_last   = outLast_q;
    assign x0         = {x0Re_q, x0Im_q};
    assign x1         = {x1Re_q, x1Im_q};
    assign out_sat    = outSat_q;
    assign ovf_sticky = ovf_q;
    assign out_cnt    = cnt_q;

endmodule

// File: tb/tb_fft_bfly_r2.sv
// Scoreboard bench for fft_bfly_r2: a rounding/truncating pair of butterflies
// (OW=29 and OW=28) share stimulus and are checked against a behavioural model.
module tb_fft_bfly_r2;
    localparam int DW  = 28;
    localparam int TW  = 16;
    localparam int SW  = 3;
    localparam int OWA = DW + 1;
    localparam int OWB = 28;

    localparam longint SATP = 134217727;
    localparam longint SATN = -134217728;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              ifft = 1'b0;
    logic              clr_ovf = 1'b0;
    logic [SW-1:0]     shift = '0;
    logic [2*DW-1:0]   data0 = '0;
    logic [2*DW-1:0]   data1 = '0;
    logic [2*TW-1:0]   w1 = '0;

    logic              outValidA, outLastA, outSatA, ovfA;
    logic [2*OWA-1:0]  x0A, x1A;
    logic [7:0]        cntA;
    logic              outValidB, outLastB, outSatB, ovfB;
    logic [2*OWB-1:0]  x0B, x1B;
    logic [7:0]        cntB;

    fft_bfly_r2 #(.DW(DW), .TW(TW), .OW(OWA), .SW(SW), .RND(1'b1)) dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .ifft(ifft), .shift(shift), .data0(data0), .data1(data1), .w1(w1),
        .clr_ovf(clr_ovf), .out_valid(outValidA), .out_last(outLastA),
        .x0(x0A), .x1(x1A), .out_sat(outSatA), .ovf_sticky(ovfA), .out_cnt(cntA)
    );

    fft_bfly_r2 #(.DW(DW), .TW(TW), .OW(OWB), .SW(SW), .RND(1'b0)) dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .ifft(ifft), .shift(shift), .data0(data0), .data1(data1), .w1(w1),
        .clr_ovf(clr_ovf), .out_valid(outValidB), .out_last(outLastB),
        .x0(x0B), .x1(x1B), .out_sat(outSatB), .ovf_sticky(ovfB), .out_cnt(cntB)
    );

    always #5 clk = ~clk;

    typedef struct { longint x0r; longint x0i; longint x1r; longint x1i; bit sat; } resT;
    typedef struct { resT a; resT b; bit last; int acc; } expT;

    expT    sb[$];
    expT    mon;
    int     checks = 0;
    int     passes = 0;
    int     cycle = 0;
    int     expCnt = 0;
    bit     prevLast = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    function automatic longint scaleModel(input longint v, input int k, input int ow,
                                          input bit rnd, output bit sat);
        longint r, hi, lo;
        r = v;
        if (rnd) r = r + (64'sd1 <<< (k - 1));
        r = r >>> k;
        hi = (64'sd1 <<< (ow - 1)) - 1;
        lo = -hi - 1;
        sat = 1'b0;
        if (r > hi) begin sat = 1'b1; r = hi; end
        if (r < lo) begin sat = 1'b1; r = lo; end
        return r;
    endfunction

    function automatic resT bflyModel(input longint d0r, d0i, d1r, d1i, wr, wi,
                                      input bit iv, input int sh, input int ow, input bit rnd);
        resT res;
        longint wiE, pr, pim, ar, ai;
        int k;
        bit s0, s1, s2, s3;
        wiE = wi;
        if (iv) wiE = (wi == -32768) ? 32767 : -wi;
        pr  = d1r * wr - d1i * wiE;
        pim = d1r * wiE + d1i * wr;
        ar  = d0r * 16384;
        ai  = d0i * 16384;
        k   = 14 + sh;
        res.x0r = scaleModel(ar + pr,  k, ow, rnd, s0);
        res.x0i = scaleModel(ai + pim, k, ow, rnd, s1);
        res.x1r = scaleModel(ar - pr,  k, ow, rnd, s2);
        res.x1i = scaleModel(ai - pim, k, ow, rnd, s3);
        res.sat = s0 | s1 | s2 | s3;
        return res;
    endfunction

    task automatic applyStimulus(input longint d0r, d0i, d1r, d1i, wr, wi,
                                 input bit iv, input int sh, input bit lst);
        expT e;
        @(negedge clk);
        in_valid = 1'b1;
        in_last  = lst;
        ifft     = iv;
        shift    = SW'(sh);
        clr_ovf  = 1'b0;
        data0    = {d0r[DW-1:0], d0i[DW-1:0]};
        data1    = {d1r[DW-1:0], d1i[DW-1:0]};
        w1       = {wr[TW-1:0], wi[TW-1:0]};
        e.a      = bflyModel(d0r, d0i, d1r, d1i, wr, wi, iv, sh, OWA, 1'b1);
        e.b      = bflyModel(d0r, d0i, d1r, d1i, wr, wi, iv, sh, OWB, 1'b0);
        e.last   = lst;
        e.acc    = cycle + 1;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            clr_ovf  = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        checkOutput(tag, sb.size(), 0);
        idle(2);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".validA"}, outValidA, 0);
        checkOutput({tag, ".lastA"},  outLastA, 0);
        checkOutput({tag, ".x0A"},    longint'(x0A), 0);
        checkOutput({tag, ".x1A"},    longint'(x1A), 0);
        checkOutput({tag, ".satA"},   outSatA, 0);
        checkOutput({tag, ".ovfA"},   ovfA, 0);
        checkOutput({tag, ".cntA"},   cntA, 0);
        checkOutput({tag, ".validB"}, outValidB, 0);
        checkOutput({tag, ".x0B"},    longint'(x0B), 0);
        checkOutput({tag, ".ovfB"},   ovfB, 0);
        checkOutput({tag, ".cntB"},   cntB, 0);
    endtask

    function automatic longint rndD();
        return longint'($urandom_range(0, 134217727)) - 67108864;
    endfunction

    function automatic longint rndW();
        return longint'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Pop one expectation per valid output and compare both instances.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prevLast) begin
                checkOutput("cntAfterLastA", cntA, 0);
                checkOutput("cntAfterLastB", cntB, 0);
            end
            prevLast = 1'b0;
            if (outValidA || outValidB) begin
                if (sb.size() == 0) begin
                    checkOutput("spuriousValidA", outValidA, 0);
                    checkOutput("spuriousValidB", outValidB, 0);
                end else begin
                    mon = sb.pop_front();
                    checkOutput("latency", cycle - mon.acc, 4);
                    checkOutput("validA", outValidA, 1);
                    checkOutput("validB", outValidB, 1);
                    checkOutput("A.x0re", longint'($signed(x0A[2*OWA-1:OWA])), mon.a.x0r);
                    checkOutput("A.x0im", longint'($signed(x0A[OWA-1:0])), mon.a.x0i);
                    checkOutput("A.x1re", longint'($signed(x1A[2*OWA-1:OWA])), mon.a.x1r);
                    checkOutput("A.x1im", longint'($signed(x1A[OWA-1:0])), mon.a.x1i);
                    checkOutput("A.sat",  outSatA, mon.a.sat);
                    checkOutput("B.x0re", longint'($signed(x0B[2*OWB-1:OWB])), mon.b.x0r);
                    checkOutput("B.x0im", longint'($signed(x0B[OWB-1:0])), mon.b.x0i);
                    checkOutput("B.x1re", longint'($signed(x1B[2*OWB-1:OWB])), mon.b.x1r);
                    checkOutput("B.x1im", longint'($signed(x1B[OWB-1:0])), mon.b.x1i);
                    checkOutput("B.sat",  outSatB, mon.b.sat);
                    checkOutput("lastA",  outLastA, mon.last);
                    checkOutput("lastB",  outLastB, mon.last);
                    checkOutput("cntA",   cntA, expCnt);
                    checkOutput("cntB",   cntB, expCnt);
                    prevLast = mon.last;
                    expCnt   = mon.last ? 0 : (expCnt + 1) % 256;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint d0r, d0i, d1r, d1i, wr, wi;
        bit iv;
        int sh;

        #1 rst_n = 1'b0;
        #3 checkAllZero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] identity, -j, ifft conjugation, rounding");
        applyStimulus(100, -50, 30, 20, 16384, 0, 1'b0, 0, 1'b1);
        idle(6);
        applyStimulus(100, -50, 30, 20, 0, -16384, 1'b0, 0, 1'b1);
        applyStimulus(100, -50, 30, 20, 0, -16384, 1'b1, 0, 1'b1);
        idle(6);
        applyStimulus(5, -5, 0, 0, 16384, 0, 1'b0, 1, 1'b1);
        applyStimulus(30, 20, 30, 20, 0, -32768, 1'b1, 2, 1'b1);
        idle(6);

        $display("[TB] saturation and sticky overflow");
        applyStimulus(SATP, SATN, SATP, SATN, 16384, 0, 1'b0, 0, 1'b1);
        idle(5);
        checkOutput("ovfBeforeRise", ovfB, 0);
        idle(1);
        checkOutput("ovfRise", ovfB, 1);
        for (int i = 0; i < 10; i++) applyStimulus(100, -50, 30, 20, 16384, 0, 1'b0, 0, 1'b1);
        idle(6);
        checkOutput("ovfHold", ovfB, 1);
        checkOutput("ovfA", ovfA, 0);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checkOutput("ovfClear", ovfB, 0);
        applyStimulus(SATP, SATN, SATP, SATN, 16384, 0, 1'b0, 0, 1'b1);
        idle(4);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr_ovf  = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checkOutput("ovfSetWins", ovfB, 1);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checkOutput("ovfClear2", ovfB, 0);
        drain("drainDirected");

        $display("[TB] streaming frame with bubbles");
        for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < 4 && $urandom_range(0, 99) < 30; b++) idle(1);
            d0r = rndD(); d0i = rndD(); d1r = rndD(); d1i = rndD();
            wr  = rndW();
            wi  = (i == 3) ? -32768 : rndW();
            iv  = (i == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            sh  = $urandom_range(0, 7);
            applyStimulus(d0r, d0i, d1r, d1i, wr, wi, iv, sh, i == 15);
        end
        drain("drainStream");

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(rndD(), rndD(), rndD(), rndD(), rndW(), rndW(),
                          1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'b0);
        end
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        sb.delete();
        expCnt   = 0;
        prevLast = 1'b0;
        #1 checkAllZero("midReset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(8);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(rndD(), rndD(), rndD(), rndD(), rndW(), rndW(),
                          1'($urandom_range(0, 1)), $urandom_range(0, 7), i == 4);
        end
        drain("drainAfterReset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fft_bfly_r2.md
# fft_bfly_r2

Parameterised, fully pipelined radix-2 DIT butterfly for the FFT datapath: x0 = d0 + d1·w, x1 = d0 − d1·w. It generalises the fixed-width two-point butterfly with runtime FFT/IFFT selection and rounding, a per-sample programmable right shift for block scaling, output saturation with sticky overflow, and valid/last sideband tracking. It is instantiated once per stage of the streaming FFT core, between the twiddle ROM and the stage reorder buffer.

## Interface
- DW, 28: bits per real/imag input component (signed).
- TW, 16: bits per twiddle component (signed). 1.0 = 2^(TW-2), so 0x4000 is 1.0 at TW=16.
- OW, DW+1: bits per output component (signed).
- SW, 3: width of the shift control.
- RND, 1: 1 = round half up before the shift; 0 = truncate.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample strobe.
- in_last  in  1  last sample of a frame; qualified by in_valid.
- ifft  in  1  1 = use conj(w1); sampled with the data.
- shift  in  SW  extra right shift, 0..2^SW-1; sampled with the data.
- data0  in  2·DW  {re, im} of the upper input.
- data1  in  2·DW  {re, im} of the lower input.
- w1  in  2·TW  {re, im} twiddle.
- clr_ovf  in  1  synchronous clear of ovf_sticky.
- out_valid  out  1  result strobe.
- out_last  out  1  delayed in_last.
- x0  out  2·OW  {re, im} of d0 + p.
- x1  out  2·OW  {re, im} of d0 − p.
- out_sat  out  1  at least one of the four output components saturated for this sample.
- ovf_sticky  out  1  set by any out_sat; held until cleared.
- out_cnt  out  8  index of the current output within its frame.

## Operation
- **S1 (input register).** Capture data0, data1, w1, ifft, shift, in_valid and in_last. When ifft=1, negate w1.im. Negating −2^(TW-1) saturates to 2^(TW-1)−1.
- **S2 (partial products).** Register the four full-precision partial products: d1re·wre, d1im·wim, d1re·wim, d1im·wre.
- **S3 (complex product).** pre = rr − ii and pim = ri + ir, each DW+TW+1 bits. Align d0 as d0 <<< (TW−2).
- **S4 (butterfly).** s = d0a + p and t = d0a − p, each DW+TW+2 bits. No intermediate truncation anywhere.
- **S5 (scale and saturate).** Total shift k = TW−2+shift.
  - If RND=1, add 2^(k−1) before the shift.
  - Arithmetic shift right by k.
  - Saturate to OW bits: clamp to 2^(OW−1)−1 or −2^(OW−1).
  - out_sat = OR of the four per-component clamp flags.
- **Valid behaviour.**
  - No backpressure; the pipeline advances every cycle.
  - Bubbles (in_valid=0) propagate. Data registers in invalid slots may hold stale values.
  - x0, x1 and out_sat change only on valid slots.
- **ovf_sticky.** Set on any out_valid & out_sat. Cleared on clr_ovf. If set and clear coincide in the same cycle, set wins.
- **out_cnt.**
  - Increments on each out_valid.
  - Reset to 0 on the cycle after an out_valid & out_last.
  - Wraps 255 → 0.
- **Reset (rst_n=0).** Asynchronously clears all of the following to 0: out_valid, out_last, x0, x1, out_sat, ovf_sticky, out_cnt, and all pipeline valid bits. In-flight samples are discarded. Nothing partial emerges after reset is released.

## Timing
- **Latency.**
  - Sample accepted at rising edge t, where in_valid=1.
  - Result registered at edge t+4, so out_valid is high for the cycle following t+4.
  - Fixed latency of 4 edges after acceptance, independent of ifft and shift.
- **Throughput.** One sample per clock. Back-to-back inputs give back-to-back outputs in the same order.
- **Sideband alignment.** out_last, out_sat and out_cnt are aligned with out_valid. ovf_sticky rises one edge after the saturating output.
- **clr_ovf.** Takes effect at the next edge.

## Test plan
1. **Identity twiddle.** DW=28, TW=16, OW=29. w1=0x4000_0000, data0=(100,−50), data1=(30,20), shift=0, ifft=0, single pulse. Required: x0=(130,−30), x1=(70,−70), out_valid exactly 4 edges after acceptance, out_sat=0.
2. **−j twiddle and IFFT conjugation.** w1={0x0000,0xC000}, same data, ifft=0. Required: x0=(120,−80), x1=(80,−20). Repeat with ifft=1. Required: x0=(80,−20), x1=(120,−80).
3. **Rounding.** data0=(5,−5), data1=0, w1=1.0, shift=1.
   - RND=1: x0=x1=(3,−2).
   - RND=0: x0=x1=(2,−3).
4. **Saturation.** OW=28, data0=data1=(2^27−1, −2^27), w1=1.0, shift=0.
   - x0=(2^27−1, −2^27) and out_sat=1.
   - ovf_sticky=1 from the next edge and holds across 10 clean samples.
   - clr_ovf pulse clears it.
   - Pulse clr_ovf on the same cycle as a new saturation: ovf_sticky stays 1.
5. **Streaming.**
   - Send 16 samples with in_last on the 16th, using a random 30% bubble pattern.
   - Outputs must match the reference model in order. out_cnt runs 0..15, out_last coincides with index 15, and out_cnt=0 on the next frame.
   - Assert rst_n=0 mid-frame for one cycle: all outputs 0 immediately, no out_valid for the dropped samples, and the next frame starts at out_cnt=0.
